// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared opcode constants and register-file sizes for the write-back scoreboard
package wb_pkg;
   localparam int REG_W = 5;
   localparam int NREG  = 32;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
endpackage

// File: rtl/wb_sb_decode.sv
// rtl/wb_sb_decode.sv - combinational decode of register usage from an instruction word
module wb_sb_decode
   import wb_pkg::*;
(
   input  logic [31:0]      ir,
   output logic [REG_W-1:0] rs1,
   output logic [REG_W-1:0] rs2,
   output logic [REG_W-1:0] rd,
   output logic             use_rs1,
   output logic             use_rs2,
   output logic             wr_rd
);
   assign rs1 = ir[19:15];
   assign rs2 = ir[24:20];
   assign rd  = ir[11:7];

   always_comb begin
      use_rs1 = 1'b0;
      use_rs2 = 1'b0;
      wr_rd   = 1'b0;
      case (ir[6:0])
         OPC_LUI, OPC_AUIPC, OPC_JAL: wr_rd = 1'b1;
         OPC_JALR, OPC_LOAD, OPC_OPIMM: begin
            use_rs1 = 1'b1;
            wr_rd   = 1'b1;
         end
         OPC_OP: begin
            use_rs1 = 1'b1;
            use_rs2 = 1'b1;
            wr_rd   = 1'b1;
         end
         OPC_STORE, OPC_BRANCH: begin
            use_rs1 = 1'b1;
            use_rs2 = 1'b1;
         end
         default: ;
      endcase
   end
endmodule

// File: rtl/wb_scoreboard.sv
// rtl/wb_scoreboard.sv - register-hazard scoreboard between decode and write-back
// Optional same-cycle retire forwarding: WB_SCOREBOARD_BYPASS_EN
module wb_scoreboard
   import wb_pkg::*;
#(
   parameter int CNT_W = 2,
   parameter int TOT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             iss_v,
   input  logic [31:0]      iss_ir,
   output logic             iss_r,
   output logic             stall,
   input  logic             wb_v,
   input  logic [REG_W-1:0] wb_rd,
   input  logic             flush,
   output logic             busy,
   output logic [TOT_W-1:0] inflight,
   output logic             err
);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [TOT_W-1:0] TOT_MAX = '1;

   logic [CNT_W-1:0] cnt [NREG];
   logic [REG_W-1:0] rs1, rs2, rd;
   logic             use_rs1, use_rs2, wr_rd;
   logic             rs1_hold, rs2_hold, rd_full;
   logic             inc, ret, ret_ok, ret_bad, ovf;

   wb_sb_decode u_decode (
      .ir      (iss_ir),
      .rs1     (rs1),
      .rs2     (rs2),
      .rd      (rd),
      .use_rs1 (use_rs1),
      .use_rs2 (use_rs2),
      .wr_rd   (wr_rd)
   );

   always_comb begin
      rs1_hold = use_rs1 && (rs1 != '0) && (cnt[rs1] != '0);
      rs2_hold = use_rs2 && (rs2 != '0) && (cnt[rs2] != '0);
`ifdef WB_SCOREBOARD_BYPASS_EN
      // A last outstanding write retiring now is forwarded by write-back.
      if (wb_v && (wb_rd == rs1) && (cnt[rs1] == CNT_ONE)) rs1_hold = 1'b0;
      if (wb_v && (wb_rd == rs2) && (cnt[rs2] == CNT_ONE)) rs2_hold = 1'b0;
`endif
      rd_full = wr_rd && (rd != '0) && (cnt[rd] == CNT_MAX);
   end

   assign iss_r = ~flush & ~rs1_hold & ~rs2_hold & ~rd_full & (inflight != TOT_MAX);
   assign stall = iss_v & ~iss_r;

   assign inc     = iss_v && iss_r && wr_rd && (rd != '0);
   assign ret     = wb_v && (wb_rd != '0) && !flush;
   assign ret_ok  = ret && (cnt[wb_rd] != '0);
   assign ret_bad = ret && (cnt[wb_rd] == '0);
   assign ovf     = inc && !ret_ok && (inflight == TOT_MAX);

   always_comb begin
      busy = 1'b0;
      for (int i = 1; i < NREG; i++) busy = busy | (cnt[i] != '0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) cnt[i] <= '0;
         inflight <= '0;
         err      <= 1'b0;
      end else if (flush) begin
         for (int i = 0; i < NREG; i++) cnt[i] <= '0;
         inflight <= '0;
      end else begin
         if (ret_bad || ovf) err <= 1'b1;
         for (int i = 1; i < NREG; i++) begin
            if (inc && (rd == REG_W'(i)) && !(ret_ok && (wb_rd == REG_W'(i))))
               cnt[i] <= cnt[i] + CNT_ONE;
            else if (ret_ok && (wb_rd == REG_W'(i)) && !(inc && (rd == REG_W'(i))))
               cnt[i] <= cnt[i] - CNT_ONE;
         end
         if (inc && !ret_ok)
            inflight <= inflight + TOT_W'(1);
         else if (ret_ok && !inc)
            inflight <= inflight - TOT_W'(1);
      end
   end
endmodule

// File: tb/tb_wb_scoreboard.sv
// tb/tb_wb_scoreboard.sv - directed self-checking bench for wb_scoreboard
module tb_wb_scoreboard;
   logic        clk = 1'b0;
   logic        rst, iss_v, wb_v, flush;
   logic [31:0] iss_ir;
   logic [4:0]  wb_rd;
   logic        iss_r, stall, busy, err;
   logic [3:0]  inflight;
   int          total = 0;
   int          bad = 0;
   logic        exp_stall_byp;

   localparam logic [31:0] ADD_5_1_2 = 32'h002082B3;
   localparam logic [31:0] SW_X5     = 32'h00502023;
   localparam logic [31:0] ADDI_X3   = 32'h00100193;
   localparam logic [31:0] ADDI_X4   = 32'h00000213;
   localparam logic [31:0] ADDI_X6   = 32'h00000313;
   localparam logic [31:0] ADDI_X7   = 32'h00000393;
   localparam logic [31:0] ADDI_X8   = 32'h00000413;
   localparam logic [31:0] ADDI_X9   = 32'h00000493;
   localparam logic [31:0] NOP       = 32'h00000013;
   localparam logic [31:0] RD_X3     = 32'h00018533;
   localparam logic [31:0] RD_X4     = 32'h00020533;
   localparam logic [31:0] RD_X6     = 32'h00030533;
   localparam logic [31:0] RD_X7     = 32'h00038433;
   localparam logic [31:0] BAD_OPC   = 32'h0002827F;

   always #5 clk = ~clk;

   wb_scoreboard #(.CNT_W(2), .TOT_W(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .iss_v    (iss_v),
      .iss_ir   (iss_ir),
      .iss_r    (iss_r),
      .stall    (stall),
      .wb_v     (wb_v),
      .wb_rd    (wb_rd),
      .flush    (flush),
      .busy     (busy),
      .inflight (inflight),
      .err      (err)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; iss_v = 1'b0; iss_ir = '0; wb_v = 1'b0; wb_rd = '0; flush = 1'b0;
      tick(); tick();
      rst = 1'b0;
      #1;
      total++; if (inflight !== 4'd0) begin bad++; $display("FAIL reset_inflight got=%0d want=0", inflight); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
      total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", err); end
      total++; if (iss_r !== 1'b1) begin bad++; $display("FAIL reset_iss_r got=%b want=1", iss_r); end
      flush = 1'b1; #1;
      total++; if (iss_r !== 1'b0) begin bad++; $display("FAIL flush_iss_r got=%b want=0", iss_r); end
      flush = 1'b0; #1;
   endtask

   task automatic test_issue();
      iss_v = 1'b1; iss_ir = ADD_5_1_2; #1;
      total++; if (iss_r !== 1'b1 || stall !== 1'b0) begin bad++; $display("FAIL issue_add iss_r=%b stall=%b want 1/0", iss_r, stall); end
      tick();
      iss_v = 1'b0; #1;
      total++; if (inflight !== 4'd1 || busy !== 1'b1) begin bad++; $display("FAIL issue_count inflight=%0d busy=%b want 1/1", inflight, busy); end
   endtask

   task automatic test_hazard();
      iss_v = 1'b1; iss_ir = BAD_OPC; #1;
      total++; if (iss_r !== 1'b1) begin bad++; $display("FAIL other_opcode iss_r=%b want=1", iss_r); end
      tick();
      total++; if (inflight !== 4'd1) begin bad++; $display("FAIL other_opcode_inflight got=%0d want=1", inflight); end
      iss_ir = SW_X5; #1;
      total++; if (stall !== 1'b1) begin bad++; $display("FAIL sw_raw_stall got=%b want=1", stall); end
      wb_v = 1'b1; wb_rd = 5'd5; #1;
`ifdef WB_SCOREBOARD_BYPASS_EN
      exp_stall_byp = 1'b0;
`else
      exp_stall_byp = 1'b1;
`endif
      total++; if (stall !== exp_stall_byp) begin bad++; $display("FAIL retire_cycle_stall got=%b want=%b", stall, exp_stall_byp); end
      tick();
      wb_v = 1'b0; #1;
      total++; if (inflight !== 4'd0 || stall !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL after_retire inflight=%0d stall=%b busy=%b want 0/0/0", inflight, stall, busy); end
      tick();
      iss_v = 1'b0;
   endtask

   task automatic test_saturate();
      iss_v = 1'b1; iss_ir = ADDI_X3;
      for (int k = 0; k < 3; k++) begin
         #1;
         total++; if (iss_r !== 1'b1) begin bad++; $display("FAIL addi_x3_%0d iss_r=%b want=1", k, iss_r); end
         tick();
      end
      total++; if (inflight !== 4'd3 || stall !== 1'b1) begin bad++; $display("FAIL sat_stall inflight=%0d stall=%b want 3/1", inflight, stall); end
      wb_v = 1'b1; wb_rd = 5'd3; #1;
      total++; if (iss_r !== 1'b0) begin bad++; $display("FAIL sat_retire_cycle iss_r=%b want=0", iss_r); end
      tick();
      wb_v = 1'b0; #1;
      total++; if (iss_r !== 1'b1 || inflight !== 4'd2) begin bad++; $display("FAIL sat_release iss_r=%b inflight=%0d want 1/2", iss_r, inflight); end
      tick();
      iss_v = 1'b0; #1;
      total++; if (inflight !== 4'd3) begin bad++; $display("FAIL sat_fourth inflight=%0d want=3", inflight); end
      iss_v = 1'b1; iss_ir = RD_X3; #1;
      total++; if (stall !== 1'b1) begin bad++; $display("FAIL read_x3_stall got=%b want=1", stall); end
      iss_v = 1'b0;
      wb_v = 1'b1; wb_rd = 5'd3;
      tick(); tick(); tick();
      wb_v = 1'b0; #1;
      total++; if (inflight !== 4'd0 || err !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL sat_drain inflight=%0d err=%b busy=%b want 0/0/0", inflight, err, busy); end
   endtask

   task automatic test_same_cycle();
      iss_v = 1'b1; iss_ir = ADDI_X7; tick();
      #1;
      total++; if (iss_r !== 1'b1) begin bad++; $display("FAIL same_reg_ready iss_r=%b want=1", iss_r); end
      wb_v = 1'b1; wb_rd = 5'd7; tick();
      iss_v = 1'b0; wb_v = 1'b0; #1;
      total++; if (inflight !== 4'd1) begin bad++; $display("FAIL same_reg_inflight got=%0d want=1", inflight); end
      iss_v = 1'b1; iss_ir = RD_X7; #1;
      total++; if (stall !== 1'b1) begin bad++; $display("FAIL same_reg_still_pending stall=%b want=1", stall); end
      iss_ir = ADDI_X6; wb_v = 1'b1; wb_rd = 5'd7; tick();
      iss_v = 1'b0; wb_v = 1'b0; #1;
      total++; if (inflight !== 4'd1) begin bad++; $display("FAIL diff_reg_inflight got=%0d want=1", inflight); end
      iss_v = 1'b1; iss_ir = RD_X7; #1;
      total++; if (stall !== 1'b0) begin bad++; $display("FAIL diff_reg_x7_free stall=%b want=0", stall); end
      iss_ir = RD_X6; #1;
      total++; if (stall !== 1'b1) begin bad++; $display("FAIL diff_reg_x6_pending stall=%b want=1", stall); end
      iss_v = 1'b0; wb_v = 1'b1; wb_rd = 5'd6; tick();
      wb_v = 1'b0; #1;
      total++; if (inflight !== 4'd0 || busy !== 1'b0) begin bad++; $display("FAIL same_cycle_drain inflight=%0d busy=%b want 0/0", inflight, busy); end
   endtask

   task automatic test_x0();
      iss_v = 1'b1; iss_ir = NOP; wb_v = 1'b1; wb_rd = 5'd0; tick();
      iss_v = 1'b0; wb_v = 1'b0; #1;
      total++; if (inflight !== 4'd0 || err !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL x0_ignored inflight=%0d err=%b busy=%b want 0/0/0", inflight, err, busy); end
   endtask

   task automatic test_inflight_max();
      iss_v = 1'b1;
      for (int r = 1; r <= 5; r++) begin
         for (int k = 0; k < 3; k++) begin
            iss_ir = (32'(r) << 7) | 32'h13;
            tick();
         end
      end
      #1;
      total++; if (inflight !== 4'd15) begin bad++; $display("FAIL max_inflight got=%0d want=15", inflight); end
      iss_ir = ADDI_X9; #1;
      total++; if (iss_r !== 1'b0 || stall !== 1'b1) begin bad++; $display("FAIL max_blocks iss_r=%b stall=%b want 0/1", iss_r, stall); end
      iss_ir = NOP; #1;
      total++; if (iss_r !== 1'b0) begin bad++; $display("FAIL max_blocks_nop iss_r=%b want=0", iss_r); end
      iss_v = 1'b0; flush = 1'b1; tick();
      flush = 1'b0; #1;
      total++; if (inflight !== 4'd0 || err !== 1'b0 || iss_r !== 1'b1) begin bad++; $display("FAIL max_flush inflight=%0d err=%b iss_r=%b want 0/0/1", inflight, err, iss_r); end
   endtask

   task automatic test_flush();
      iss_v = 1'b1;
      iss_ir = ADDI_X4; tick();
      iss_ir = ADDI_X6; tick();
      iss_ir = ADDI_X8; tick();
      #1;
      total++; if (inflight !== 4'd3) begin bad++; $display("FAIL flush_setup inflight=%0d want=3", inflight); end
      iss_ir = ADDI_X9; flush = 1'b1; #1;
      total++; if (iss_r !== 1'b0 || stall !== 1'b1) begin bad++; $display("FAIL flush_issue iss_r=%b stall=%b want 0/1", iss_r, stall); end
      tick();
      flush = 1'b0; iss_v = 1'b0; #1;
      total++; if (busy !== 1'b0 || inflight !== 4'd0) begin bad++; $display("FAIL flush_clear busy=%b inflight=%0d want 0/0", busy, inflight); end
      iss_v = 1'b1; iss_ir = RD_X4; #1;
      total++; if (iss_r !== 1'b1) begin bad++; $display("FAIL flush_x4_free iss_r=%b want=1", iss_r); end
      iss_v = 1'b0;
   endtask

   task automatic test_err();
      wb_v = 1'b1; wb_rd = 5'd9; tick();
      wb_v = 1'b0; #1;
      total++; if (err !== 1'b1 || inflight !== 4'd0) begin bad++; $display("FAIL err_set err=%b inflight=%0d want 1/0", err, inflight); end
      flush = 1'b1; tick();
      flush = 1'b0; #1;
      total++; if (err !== 1'b1) begin bad++; $display("FAIL err_kept_flush got=%b want=1", err); end
      iss_v = 1'b1; iss_ir = ADDI_X7; tick();
      iss_v = 1'b0; rst = 1'b1; tick();
      rst = 1'b0; #1;
      total++; if (err !== 1'b0 || inflight !== 4'd0 || busy !== 1'b0) begin bad++; $display("FAIL rst_clear err=%b inflight=%0d busy=%b want 0/0/0", err, inflight, busy); end
   endtask

   initial begin
      test_reset();
      test_issue();
      test_hazard();
      test_saturate();
      test_same_cycle();
      test_x0();
      test_inflight_max();
      test_flush();
      test_err();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
